// File: rtl/xiyiji_key_panel_pkg.sv
// Shared constants, mode encodings and helpers for the washer key panel.
// Package xiyiji_pkg is imported by the panel interface, debouncer and top.
package xiyiji_pkg;

  localparam int MODE_W          = 2;
  localparam int DEB_CYCLES_DEF  = 4;
  localparam int NUM_MODES_DEF   = 3;
  localparam int LONG_CYCLES_DEF = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_STD   = 2'd0,
    MODE_QUICK = 2'd1,
    MODE_HEAVY = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } key_evt_t;

  function automatic logic [MODE_W-1:0] mode_next(
    input logic [MODE_W-1:0] m,
    input int                n
  );
    if (int'(m) >= n - 1)
      return MODE_STD;
    else
      return m + 1'b1;
  endfunction

endpackage

// File: rtl/xiyiji_key_panel_if.sv
// Key panel bundle: raw keys and busy in, clean events and mode out.
// master = panel side, slave = controller/board side.
interface xiyiji_key_panel_if;
  import xiyiji_pkg::*;

  logic              select_key;
  logic              start_key;
  logic              emergency_key;
  logic              busy;
  logic              select_pulse;
  logic              start_pulse;
  logic              emergency_n;
  logic              estop;
  logic [MODE_W-1:0] mode_c;

  modport master (
    input  select_key,
    input  start_key,
    input  emergency_key,
    input  busy,
    output select_pulse,
    output start_pulse,
    output emergency_n,
    output estop,
    output mode_c
  );

  modport slave (
    output select_key,
    output start_key,
    output emergency_key,
    output busy,
    input  select_pulse,
    input  start_pulse,
    input  emergency_n,
    input  estop,
    input  mode_c
  );

endinterface

// File: rtl/xiyiji_key_panel_key_debounce.sv
// Two-flop synchroniser plus stability counter for one raw key.
// rise_o/fall_o flag the edge on which the debounced level will change.
module key_debounce
  import xiyiji_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic IDLE       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          sync1_q;
  logic          s_q;
  logic          d_q;
  logic          d_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    d_d   = d_q;
    cnt_d = '0;
    if (s_q != d_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1))
        d_d = s_q;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= IDLE;
      s_q     <= IDLE;
      d_q     <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      s_q     <= sync1_q;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = d_q;
  assign rise_o  = d_d & ~d_q;
  assign fall_o  = ~d_d & d_q;

endmodule

// File: rtl/xiyiji_key_panel.sv
// Front-panel conditioner: debounced key events, wash mode and e-stop latch.
// Optional KEY_LONGPRESS_EN: long select hold resets mode to MODE_STD.
module xiyiji_key_panel
  import xiyiji_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int NUM_MODES   = NUM_MODES_DEF,
  parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
  input logic                 clk,
  input logic                 rst,
  xiyiji_key_panel_if.master  kp
);

  key_evt_t sel;
  key_evt_t st;
  key_evt_t emg;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .IDLE       (1'b0)
  ) u_sel (
    .clk     (clk),
    .rst     (rst),
    .key_i   (kp.select_key),
    .level_o (sel.level),
    .rise_o  (sel.rise),
    .fall_o  (sel.fall)
  );

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .IDLE       (1'b0)
  ) u_st (
    .clk     (clk),
    .rst     (rst),
    .key_i   (kp.start_key),
    .level_o (st.level),
    .rise_o  (st.rise),
    .fall_o  (st.fall)
  );

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .IDLE       (1'b1)
  ) u_emg (
    .clk     (clk),
    .rst     (rst),
    .key_i   (kp.emergency_key),
    .level_o (emg.level),
    .rise_o  (emg.rise),
    .fall_o  (emg.fall)
  );

  logic long_fire;

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES) + 1;

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          done_q;
  logic          done_d;

  // One event per hold: done_q saturates until select is released
  always_comb begin
    hold_d    = hold_q;
    done_d    = done_q;
    long_fire = 1'b0;
    if (!sel.level) begin
      hold_d = '0;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (hold_q == HW'(LONG_CYCLES - 1)) begin
        if (!kp.busy) begin
          long_fire = 1'b1;
          done_d    = 1'b1;
        end
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      done_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      done_q <= done_d;
    end
  end
`else
  assign long_fire = 1'b0;
`endif

  logic              sel_pulse_q;
  logic              sel_pulse_d;
  logic              st_pulse_q;
  logic              st_pulse_d;
  logic              estop_q;
  logic              estop_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;

  always_comb begin
    sel_pulse_d = sel.rise | long_fire;
    mode_d      = mode_q;
    estop_d     = estop_q;
    if (sel.rise && !kp.busy)
      mode_d = mode_next(mode_q, NUM_MODES);
    if (long_fire)
      mode_d = MODE_STD;
    // A falling emergency beats any start press in the same cycle
    if (emg.fall)
      estop_d = 1'b1;
    else if (st.rise && estop_q && emg.level)
      estop_d = 1'b0;
    st_pulse_d = st.rise & ~estop_q & ~emg.fall;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_pulse_q <= 1'b0;
      st_pulse_q  <= 1'b0;
      estop_q     <= 1'b0;
      mode_q      <= MODE_STD;
    end else begin
      sel_pulse_q <= sel_pulse_d;
      st_pulse_q  <= st_pulse_d;
      estop_q     <= estop_d;
      mode_q      <= mode_d;
    end
  end

  logic unused_evt;
  assign unused_evt = ^{sel.level, sel.fall, st.level, st.fall, emg.rise};

  assign kp.select_pulse = sel_pulse_q;
  assign kp.start_pulse  = st_pulse_q;
  assign kp.emergency_n  = emg.level;
  assign kp.estop        = estop_q;
  assign kp.mode_c       = mode_q;

endmodule

// File: tb/tb_xiyiji_key_panel.sv
// Directed bench for xiyiji_key_panel with default parameters.
// Long-press scenario runs only when KEY_LONGPRESS_EN is defined.
module tb_xiyiji_key_panel;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  xiyiji_key_panel_if kp ();

  xiyiji_key_panel u_dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst              = 1'b0;
    kp.select_key    = 1'b0;
    kp.start_key     = 1'b0;
    kp.emergency_key = 1'b1;
    kp.busy          = 1'b0;
    tick(3);
    n_checks++;
    if (kp.select_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_select_pulse got %b want 0", kp.select_pulse);
    end
    n_checks++;
    if (kp.start_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_pulse got %b want 0", kp.start_pulse);
    end
    n_checks++;
    if (kp.mode_c !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mode got %0d want 0", kp.mode_c);
    end
    n_checks++;
    if (kp.estop !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_estop got %b want 0", kp.estop);
    end
    n_checks++;
    if (kp.emergency_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_emergency_n got %b want 1", kp.emergency_n);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_bounce;
    int pulses;
    pulses = 0;
    kp.select_key = 1'b1;
    tick(3);
    kp.select_key = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (kp.select_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL bounce_pulses got %0d want 0", pulses);
    end
    n_checks++;
    if (kp.mode_c !== 2'd0) begin
      n_fail++;
      $display("FAIL bounce_mode got %0d want 0", kp.mode_c);
    end
  endtask

  task automatic test_single_press;
    int pulses;
    pulses = 0;
    kp.select_key = 1'b1;
    tick(5);
    n_checks++;
    if (kp.select_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL press_early got %b want 0", kp.select_pulse);
    end
    tick(1);
    n_checks++;
    if (kp.select_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL press_pulse got %b want 1", kp.select_pulse);
    end
    n_checks++;
    if (kp.mode_c !== 2'd1) begin
      n_fail++;
      $display("FAIL press_mode got %0d want 1", kp.mode_c);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (kp.select_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL press_hold_extra got %0d want 0", pulses);
    end
    kp.select_key = 1'b0;
    tick(10);
  endtask

  task automatic test_mode_cycle;
    logic [1:0] exp_mode [4];
    exp_mode[0] = 2'd2;
    exp_mode[1] = 2'd0;
    exp_mode[2] = 2'd1;
    exp_mode[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      kp.busy       = (i == 3);
      kp.select_key = 1'b1;
      tick(6);
      n_checks++;
      if (kp.select_pulse !== 1'b1) begin
        n_fail++;
        $display("FAIL cycle_pulse[%0d] got %b want 1", i, kp.select_pulse);
      end
      n_checks++;
      if (kp.mode_c !== exp_mode[i]) begin
        n_fail++;
        $display("FAIL cycle_mode[%0d] got %0d want %0d",
                 i, kp.mode_c, exp_mode[i]);
      end
      kp.select_key = 1'b0;
      tick(8);
    end
    kp.busy = 1'b0;
  endtask

  task automatic test_emergency;
    int pulses;
    pulses = 0;
    kp.emergency_key = 1'b0;
    tick(5);
    n_checks++;
    if (kp.emergency_n !== 1'b1 || kp.estop !== 1'b0) begin
      n_fail++;
      $display("FAIL emg_early got n=%b estop=%b want n=1 estop=0",
               kp.emergency_n, kp.estop);
    end
    tick(1);
    n_checks++;
    if (kp.emergency_n !== 1'b0 || kp.estop !== 1'b1) begin
      n_fail++;
      $display("FAIL emg_fall got n=%b estop=%b want n=0 estop=1",
               kp.emergency_n, kp.estop);
    end
    kp.start_key = 1'b1;
    tick(4);
    kp.emergency_key = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (kp.start_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || kp.estop !== 1'b1 || kp.emergency_n !== 1'b1) begin
      n_fail++;
      $display("FAIL emg_swallow got pulses=%0d estop=%b n=%b want 0 1 1",
               pulses, kp.estop, kp.emergency_n);
    end
    kp.start_key = 1'b0;
    tick(10);
    kp.start_key = 1'b1;
    tick(6);
    n_checks++;
    if (kp.estop !== 1'b0 || kp.start_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL emg_clear got estop=%b pulse=%b want 0 0",
               kp.estop, kp.start_pulse);
    end
    kp.start_key = 1'b0;
    tick(10);
    kp.start_key = 1'b1;
    tick(6);
    n_checks++;
    if (kp.start_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL start_after_clear got %b want 1", kp.start_pulse);
    end
    tick(1);
    n_checks++;
    if (kp.start_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL start_one_cycle got %b want 0", kp.start_pulse);
    end
    kp.start_key = 1'b0;
    tick(10);
  endtask

  task automatic test_simultaneous;
    kp.select_key = 1'b1;
    kp.start_key  = 1'b1;
    tick(6);
    n_checks++;
    if (kp.select_pulse !== 1'b1 || kp.start_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_pulses got sel=%b st=%b want 1 1",
               kp.select_pulse, kp.start_pulse);
    end
    n_checks++;
    if (kp.mode_c !== 2'd2) begin
      n_fail++;
      $display("FAIL simul_mode got %0d want 2", kp.mode_c);
    end
    kp.select_key = 1'b0;
    kp.start_key  = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_mid_press;
    kp.start_key = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (kp.mode_c !== 2'd0 || kp.start_pulse !== 1'b0 ||
        kp.estop !== 1'b0 || kp.emergency_n !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_outputs got m=%0d st=%b es=%b n=%b want 0 0 0 1",
               kp.mode_c, kp.start_pulse, kp.estop, kp.emergency_n);
    end
    rst = 1'b1;
    tick(5);
    n_checks++;
    if (kp.start_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_early got %b want 0", kp.start_pulse);
    end
    tick(1);
    n_checks++;
    if (kp.start_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pulse got %b want 1", kp.start_pulse);
    end
    kp.start_key = 1'b0;
    tick(10);
  endtask

`ifdef KEY_LONGPRESS_EN
  task automatic test_longpress;
    int pulses;
    pulses = 0;
    for (int i = 1; i <= 2; i++) begin
      kp.select_key = 1'b1;
      tick(6);
      n_checks++;
      if (kp.mode_c !== 2'(i)) begin
        n_fail++;
        $display("FAIL lp_setup[%0d] got %0d want %0d", i, kp.mode_c, i);
      end
      kp.select_key = 1'b0;
      tick(10);
    end
    kp.select_key = 1'b1;
    tick(6);
    n_checks++;
    if (kp.select_pulse !== 1'b1 || kp.mode_c !== 2'd0) begin
      n_fail++;
      $display("FAIL lp_first got p=%b m=%0d want 1 0",
               kp.select_pulse, kp.mode_c);
    end
    tick(15);
    n_checks++;
    if (kp.select_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL lp_early got %b want 0", kp.select_pulse);
    end
    tick(1);
    n_checks++;
    if (kp.select_pulse !== 1'b1 || kp.mode_c !== 2'd0) begin
      n_fail++;
      $display("FAIL lp_fire got p=%b m=%0d want 1 0",
               kp.select_pulse, kp.mode_c);
    end
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (kp.select_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || kp.mode_c !== 2'd0) begin
      n_fail++;
      $display("FAIL lp_saturate got pulses=%0d m=%0d want 0 0",
               pulses, kp.mode_c);
    end
    kp.select_key = 1'b0;
    tick(10);
  endtask
`else
  task automatic test_long_hold;
    int pulses;
    pulses = 0;
    kp.select_key = 1'b1;
    tick(6);
    n_checks++;
    if (kp.select_pulse !== 1'b1 || kp.mode_c !== 2'd1) begin
      n_fail++;
      $display("FAIL long_first got p=%b m=%0d want 1 1",
               kp.select_pulse, kp.mode_c);
    end
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (kp.select_pulse === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || kp.mode_c !== 2'd1) begin
      n_fail++;
      $display("FAIL long_hold got pulses=%0d m=%0d want 0 1",
               pulses, kp.mode_c);
    end
    kp.select_key = 1'b0;
    tick(10);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_bounce();
    test_single_press();
    test_mode_cycle();
    test_emergency();
    test_simultaneous();
    test_reset_mid_press();
`ifdef KEY_LONGPRESS_EN
    test_longpress();
`else
    test_long_hold();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
